// File: rtl/btn_pkg.sv
// Shared constants, repeat-FSM state type and helpers for the push-button front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package btn_pkg;

  // Button bit positions inside every N_BTN-wide vector, {D,U,L,R,C}.
  localparam int BTN_C = 0;
  localparam int BTN_R = 1;
  localparam int BTN_L = 2;
  localparam int BTN_U = 3;
  localparam int BTN_D = 4;

  // Default timing at 100 MHz.
  localparam int DEF_N_BTN      = 5;
  localparam int DEF_DB_CYCLES  = 1_000_000;
  localparam int DEF_RPT_DELAY  = 50_000_000;
  localparam int DEF_RPT_PERIOD = 10_000_000;
  localparam logic [DEF_N_BTN-1:0] DEF_RPT_MASK = 5'b11110;

  // Per-button auto-repeat state.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HELD   = 2'd3
  } rptState_t;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bus between the raw pins / consumer and the conditioner.
// Latency: n/a (wiring only).
// Backpressure: none; pulses are fire-and-forget.
// Ports: btn_raw (async levels in), btn_level / btn_press / btn_any (conditioned out).
interface btn_conditioner_if
  import btn_pkg::*;
#(
  parameter int N_BTN = DEF_N_BTN
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic             btn_any;

  // master: board / stimulus side; slave: the conditioner itself.
  modport master (output btn_raw, input btn_level, input btn_press, input btn_any);
  modport slave  (input btn_raw, output btn_level, output btn_press, output btn_any);
endinterface

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, debounce counter and auto-repeat request FSM.
// Latency: levelOut/reqOut change DB_CYCLES+2 edges after the first sample of a stable raw change.
// Backpressure: none; reqOut is a single-cycle request that the arbiter may drop.
// Ports: clk, rstN (sync active-low), rawIn (async), levelOut (debounced), reqOut (press request).
module btn_channel
  import btn_pkg::*;
#(
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD,
  parameter bit RPT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rstN,
  input  logic rawIn,
  output logic levelOut,
  output logic reqOut
);

  localparam int CNT_MAX = maxOf3(DB_CYCLES, RPT_DELAY, RPT_PERIOD);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  logic s1, s2, levelQ;
  logic [CNT_W-1:0] dbCnt;
  logic dbHit, levelRise, levelFall;

  rptState_t state, stateNext;
  logic [CNT_W-1:0] rptCnt, rptCntNext;
  logic reqQ, reqNext;

  // dbHit marks the edge on which the level flips; the FSM sees rise/fall on that same edge.
  assign dbHit     = (s2 != levelQ) && (dbCnt == DB_LAST);
  assign levelRise = dbHit & s2;
  assign levelFall = dbHit & ~s2;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      levelQ <= 1'b0;
      dbCnt  <= '0;
    end else begin
      s1 <= rawIn;
      s2 <= s1;
      if (s2 == levelQ) begin
        dbCnt <= '0;
      end else if (dbHit) begin
        levelQ <= s2;
        dbCnt  <= '0;
      end else if (dbCnt != CNT_SAT) begin
        dbCnt <= dbCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state  <= ST_IDLE;
      rptCnt <= '0;
      reqQ   <= 1'b0;
    end else begin
      state  <= stateNext;
      rptCnt <= rptCntNext;
      reqQ   <= reqNext;
    end
  end

  always_comb begin
    stateNext  = state;
    rptCntNext = rptCnt;
    reqNext    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (levelRise) begin
          reqNext    = 1'b1;
          rptCntNext = '0;
          stateNext  = RPT_EN ? ST_DELAY : ST_HELD;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        // A release on the expiry edge wins: no request.
        if (levelFall) begin
          stateNext  = ST_IDLE;
          rptCntNext = '0;
        end else if (rptCnt == ((state == ST_DELAY) ? DLY_LAST : PER_LAST)) begin
          reqNext    = 1'b1;
          rptCntNext = '0;
          stateNext  = ST_REPEAT;
        end else if (rptCnt != CNT_SAT) begin
          rptCntNext = rptCnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (levelFall) begin
          stateNext = ST_IDLE;
        end
      end
      default: begin
        stateNext  = ST_IDLE;
        rptCntNext = '0;
      end
    endcase
  end

  assign levelOut = levelQ;
  assign reqOut   = reqQ;

endmodule

// File: rtl/btn_conditioner.sv
// Five-button front end: per-button conditioning plus fixed-priority press arbitration.
// Latency: btn_press one edge after the channel request (DB_CYCLES+3 edges after the first stable raw sample).
// Backpressure: none; simultaneous requests other than the lowest index are dropped.
// Ports: clk, btnCpuReset (sync active-low), bus (slave: btn_raw in, btn_level/btn_press/btn_any out).
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN      = DEF_N_BTN,
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD,
  parameter logic [N_BTN-1:0] RPT_MASK = N_BTN'(DEF_RPT_MASK)
) (
  input  logic clk,
  input  logic btnCpuReset,
  btn_conditioner_if.slave bus
);

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] req;
  logic [N_BTN-1:0] grant;
  logic [N_BTN-1:0] pressQ;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : gChan
    btn_channel #(
      .DB_CYCLES (DB_CYCLES),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD),
      .RPT_EN    (RPT_MASK[gi])
    ) uChan (
      .clk     (clk),
      .rstN    (btnCpuReset),
      .rawIn   (bus.btn_raw[gi]),
      .levelOut(level[gi]),
      .reqOut  (req[gi])
    );
  end

  // Two's-complement trick isolates the lowest set request bit.
  assign grant = req & (~req + N_BTN'(1));

  always_ff @(posedge clk) begin
    if (!btnCpuReset) begin
      pressQ <= '0;
    end else begin
      pressQ <= grant;
    end
  end

  assign bus.btn_level = level;
  assign bus.btn_press = pressQ;
  assign bus.btn_any   = |level;

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end conditioning stage for the five board push-buttons, directly upstream of `btn_flsm`. It synchronizes each raw button input and debounces it with a per-button counter. It generates single-cycle press pulses, with auto-repeat on the four direction buttons. The pulses are arbitrated so that at most one press reaches the cursor/move state machine per cycle.

## Interface
Parameters:
- `N_BTN`, 5, number of buttons; bit order {D,U,L,R,C} = [4:0], C is bit 0.
- `DB_CYCLES`, 1_000_000, cycles of stable input needed to accept a change (10 ms at 100 MHz); must be ≥ 1.
- `RPT_DELAY`, 50_000_000, hold cycles from first pulse to first repeat pulse.
- `RPT_PERIOD`, 10_000_000, cycles between later repeat pulses.
- `RPT_MASK`, 5'b11110, per-button auto-repeat enable; the C button never repeats.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `btnCpuReset` in 1: synchronous, active-low reset, sampled on rising `clk`.
- `btn_raw` in N_BTN: asynchronous raw button levels, active high.
- `btn_level` out N_BTN: debounced level per button.
- `btn_press` out N_BTN: registered pulse, at most one bit high per cycle.
- `btn_any` out 1: OR of `btn_level`.

## Operation
- **Reset.** While `btnCpuReset`=0 at a clk edge, all of the following clear to 0: sync flops, counters, `btn_level`, `btn_press`, `btn_any`. All FSMs go to IDLE. Reset has priority over every other event.
- **Synchronizer.** Each bit passes through a 2-flop synchronizer (s1 → s2).
- **Debounce (per button).**
  - If s2 ≠ level, the counter increments.
  - If s2 = level, the counter clears.
  - When the counter reaches DB_CYCLES-1 while s2 ≠ level, level ← s2 and the counter clears on that edge.
  - A glitch shorter than DB_CYCLES cycles never changes the level.
- **Repeat FSM (per button).** States IDLE, DELAY, REPEAT, HELD.
  - IDLE: on a level rise, raise a pulse request. Go to DELAY if the RPT_MASK bit is 1, otherwise HELD. The repeat counter is set to 0.
  - DELAY: a level fall goes to IDLE. When the counter reaches RPT_DELAY-1, raise a request, go to REPEAT, and clear the counter.
  - REPEAT: a level fall goes to IDLE. When the counter reaches RPT_PERIOD-1, raise a request and clear the counter.
  - HELD: a level fall goes to IDLE.
- **Arbitration.** `btn_press` ← the lowest-index requesting bit only. Losing requests in the same cycle are dropped, not deferred.
- **Width rules.** Counters are sized to $clog2 of the larger of DB_CYCLES, RPT_DELAY and RPT_PERIOD. Counters saturate and never wrap in any state.
- **Reset release with a button held.** The held button is debounced normally and produces one press after DB_CYCLES. This behaviour is intended.

## Timing
- **Press latency.** Raw rises and stays stable, first sampled at edge E.
  - s2 is high after edge E+1.
  - `btn_level` and the request both occur at edge E+1+DB_CYCLES.
  - `btn_press` is high for exactly one cycle after edge E+2+DB_CYCLES, because it is registered after arbitration.
- **Release latency.** `btn_level` falls at edge E+1+DB_CYCLES after the first low sample. A release never generates `btn_press`.
- **Repeat spacing.** Pulses from one held button are spaced RPT_DELAY cycles (first to second), then RPT_PERIOD cycles thereafter.
- **Reset mid-operation.**
  - Outputs are 0 in the cycle after the reset edge.
  - A pulse that would have fired on that edge is lost.
- **Level fall during DELAY or REPEAT on the same edge as counter expiry.** The fall wins: no request, go to IDLE.

## Structure
- **Package `btn_pkg`.**
  - Button index constants: BTN_C=0, BTN_R=1, BTN_L=2, BTN_U=3, BTN_D=4.
  - Repeat FSM state type and encoding.
  - Default timing constants.
- **Sub-module `btn_channel`.** Contains the synchronizer, debounce counter and repeat FSM for one button. It is instantiated N_BTN times via generate, with its RPT_MASK bit passed as a parameter.
- **Top.** Holds the fixed-priority arbiter, the output registers and the `btn_any` OR.

## Test plan
Run with DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8.
- **Single press.** Raise `btn_raw[0]` at edge 10 and hold 100 cycles → `btn_level[0]`=1 from edge 15. `btn_press`=5'b00001 for exactly one cycle after edge 16. No repeats, since C is masked.
- **Glitch rejection.** Pulse `btn_raw[3]` high for 3 cycles, low for 1, then high for 3 → `btn_level` and `btn_press` stay 0.
- **Auto-repeat.** Hold `btn_raw[1]` for 60 cycles → `btn_press[1]` pulses at relative cycles 0, 20, 28, 36, 44, 52. No pulse after the level falls.
- **Simultaneous press.** Raise bits 2 and 4 on the same edge → only `btn_press`=5'b00100. `btn_level`=5'b10100 and `btn_any`=1.
- **Reset mid-operation.** Hold `btn_raw[3]`, assert `btnCpuReset`=0 for 2 cycles in DELAY, then release → all outputs are 0 the cycle after the reset edge. Exactly one fresh press occurs DB_CYCLES+3 edges after reset deasserts.
- **Release edge vs. expiry.** Drop `btn_level[2]` on the same edge as RPT_DELAY expiry → no `btn_press[2]`, and the FSM returns to IDLE.
